// File: rtl/ds1302_responder_pkg.sv
// Shared definitions for the DS1302 responder: register map, serial FSM encoding,
// and BCD calendar helpers.
package ds1302_responder_pkg;

  localparam logic [2:0] A_SEC   = 3'd0;
  localparam logic [2:0] A_MIN   = 3'd1;
  localparam logic [2:0] A_HOUR  = 3'd2;
  localparam logic [2:0] A_DATE  = 3'd3;
  localparam logic [2:0] A_MONTH = 3'd4;
  localparam logic [2:0] A_WEEK  = 3'd5;
  localparam logic [2:0] A_YEAR  = 3'd6;
  localparam logic [2:0] A_CTRL  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD,
    ST_IGNORE
  } state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD year 00..99 maps to 2000..2099, so divisible-by-4 is the whole leap rule
  function automatic logic is_leap(input logic [7:0] yr);
    if (yr[4])
      return (yr[3:0] == 4'd2) || (yr[3:0] == 4'd6);
    else
      return (yr[3:0] == 4'd0) || (yr[3:0] == 4'd4) || (yr[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] days_in_month(input logic [7:0] mon, input logic [7:0] yr);
    case (mon)
      8'h02:                      return is_leap(yr) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/ds1302_responder_time_core.sv
// Timekeeping register file: 1 Hz divider, BCD calendar cascade, CH/WP gating,
// one write port and a combinational read port.
module ds1302_responder_time_core
  import ds1302_responder_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [2:0]  addr_i,
  input  logic [7:0]  wdata_i,
  input  logic [2:0]  raddr_i,
  output logic [7:0]  rdata_o,
  output logic [55:0] time_bcd_o
);

  localparam int DIV_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_FREQ - 1);

  logic [7:0] sec_q, min_q, hour_q, date_q, month_q, week_q, year_q;
  logic [7:0] sec_d, min_d, hour_d, date_d, month_d, week_d, year_d;
  logic       wp_q, wp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic tick, wr_ok, wr_time;

  assign tick    = ~sec_q[7] && (div_q == DIV_TC);
  assign wr_ok   = we_i && ((addr_i == A_CTRL) || !wp_q);
  assign wr_time = wr_ok && (addr_i != A_CTRL);

  always_comb begin
    sec_d = sec_q;  min_d = min_q;  hour_d = hour_q;  date_d = date_q;
    month_d = month_q;  week_d = week_q;  year_d = year_q;  wp_d = wp_q;
    div_d = div_q;
    if (!sec_q[7]) div_d = tick ? '0 : div_q + DIV_W'(1);
    // a commit to any time register in the tick cycle swallows that tick
    if (tick && !wr_time) begin
      sec_d = (sec_q == 8'h59) ? 8'h00 : bcd_inc(sec_q);
      if (sec_q == 8'h59) begin
        min_d = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
        if (min_q == 8'h59) begin
          hour_d = (hour_q == 8'h23) ? 8'h00 : bcd_inc(hour_q);
          if (hour_q == 8'h23) begin
            week_d = (week_q == 8'h07) ? 8'h01 : bcd_inc(week_q);
            if (date_q >= days_in_month(month_q, year_q)) begin
              date_d  = 8'h01;
              month_d = (month_q == 8'h12) ? 8'h01 : bcd_inc(month_q);
              if (month_q == 8'h12) year_d = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);
            end else begin
              date_d = bcd_inc(date_q);
            end
          end
        end
      end
    end
    if (wr_ok) begin
      case (addr_i)
        A_SEC:   begin sec_d = wdata_i; div_d = '0; end
        A_MIN:   min_d   = wdata_i;
        A_HOUR:  hour_d  = wdata_i;
        A_DATE:  date_d  = wdata_i;
        A_MONTH: month_d = wdata_i;
        A_WEEK:  week_d  = wdata_i;
        A_YEAR:  year_d  = wdata_i;
        A_CTRL:  wp_d    = wdata_i[7];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_q <= 8'h00;  min_q <= 8'h00;  hour_q <= 8'h00;  date_q <= 8'h01;
      month_q <= 8'h01;  week_q <= 8'h01;  year_q <= 8'h00;  wp_q <= 1'b0;
      div_q <= '0;
    end else begin
      sec_q <= sec_d;  min_q <= min_d;  hour_q <= hour_d;  date_q <= date_d;
      month_q <= month_d;  week_q <= week_d;  year_q <= year_d;  wp_q <= wp_d;
      div_q <= div_d;
    end
  end

  always_comb begin
    case (raddr_i)
      A_SEC:   rdata_o = sec_q;
      A_MIN:   rdata_o = min_q;
      A_HOUR:  rdata_o = hour_q;
      A_DATE:  rdata_o = date_q;
      A_MONTH: rdata_o = month_q;
      A_WEEK:  rdata_o = week_q;
      A_YEAR:  rdata_o = year_q;
      A_CTRL:  rdata_o = {wp_q, 7'b0};
    endcase
  end

  assign time_bcd_o = {year_q, week_q, month_q, date_q, hour_q, min_q, 1'b0, sec_q[6:0]};

endmodule

// File: rtl/ds1302_responder.sv
// DS1302 device-side emulation: synchronised 3-wire serial FSM in front of the
// timekeeping core.
//   state     | meaning
//   ST_IDLE   | waiting for CE rising
//   ST_CMD    | shifting in command byte on SCLK rises
//   ST_WR     | shifting in write data, commit on 8th rise
//   ST_RD     | driving read data LSB first on SCLK falls
//   ST_IGNORE | transaction done or unsupported, wait for CE low
module ds1302_responder
  import ds1302_responder_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ds1302_ce,
  input  logic        ds1302_sclk,
  input  logic        ds1302_io_in,
  output logic        ds1302_io_out,
  output logic        ds1302_io_oe,
  output logic [55:0] time_bcd
);

  logic [SYNC_STAGES-1:0] ce_sync_q, sclk_sync_q, io_sync_q;
  logic ce_prev_q, sclk_prev_q;
  logic ce_s, sclk_s, io_s, ce_rise, sclk_rise, sclk_fall;

  state_e     state_q;
  logic [2:0] bit_cnt_q, addr_q;
  logic [7:0] sh_q, shift_in, core_rdata;
  logic       rd_live_q, core_we;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ce_sync_q <= '0;  sclk_sync_q <= '0;  io_sync_q <= '0;
      ce_prev_q <= 1'b0;  sclk_prev_q <= 1'b0;
    end else begin
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ds1302_ce};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ds1302_sclk};
      io_sync_q   <= {io_sync_q[SYNC_STAGES-2:0], ds1302_io_in};
      ce_prev_q   <= ce_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign ce_s      = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign io_s      = io_sync_q[SYNC_STAGES-1];
  assign ce_rise   = ce_s & ~ce_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign shift_in  = {io_s, sh_q[7:1]};
  assign core_we   = ce_s && (state_q == ST_WR) && sclk_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !ce_s) begin
      state_q <= ST_IDLE;  bit_cnt_q <= 3'd0;  rd_live_q <= 1'b0;
      ds1302_io_oe <= 1'b0;  ds1302_io_out <= 1'b0;
      if (sys_rst) begin
        sh_q <= 8'h00;  addr_q <= 3'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE: if (ce_rise) begin
          state_q <= ST_CMD;  bit_cnt_q <= 3'd0;
        end
        ST_CMD: if (sclk_rise) begin
          sh_q <= shift_in;  bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // clock registers only: bit7 set, RAM bit clear, address 0..7
            if (shift_in[7] && !shift_in[6] && (shift_in[5:4] == 2'b00)) begin
              addr_q    <= shift_in[3:1];
              rd_live_q <= 1'b0;
              state_q   <= shift_in[0] ? ST_RD : ST_WR;
            end else begin
              state_q <= ST_IGNORE;
            end
          end
        end
        ST_WR: if (sclk_rise) begin
          sh_q <= shift_in;  bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= ST_IGNORE;
        end
        ST_RD: if (sclk_fall) begin
          if (!rd_live_q) begin
            sh_q <= {1'b0, core_rdata[7:1]};  ds1302_io_out <= core_rdata[0];
            ds1302_io_oe <= 1'b1;  rd_live_q <= 1'b1;  bit_cnt_q <= 3'd0;
          end else if (bit_cnt_q == 3'd7) begin
            ds1302_io_oe <= 1'b0;  ds1302_io_out <= 1'b0;  state_q <= ST_IGNORE;
          end else begin
            sh_q <= {1'b0, sh_q[7:1]};  ds1302_io_out <= sh_q[0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        default: begin
          ds1302_io_oe <= 1'b0;  ds1302_io_out <= 1'b0;
        end
      endcase
    end
  end

  ds1302_responder_time_core #(.CLK_FREQ(CLK_FREQ)) u_time_core (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .we_i       (core_we),
    .addr_i     (addr_q),
    .wdata_i    (shift_in),
    .raddr_i    (addr_q),
    .rdata_o    (core_rdata),
    .time_bcd_o (time_bcd)
  );

endmodule

// File: tb/tb_ds1302_responder.sv
// Table-driven bench for ds1302_responder with a read-data scoreboard.
module tb_ds1302_responder;

  localparam int CLK_FREQ = 2000;
  localparam int HALF     = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ce = 1'b0, sclk = 1'b0, io = 1'b0;
  logic        io_out, io_oe;
  logic [55:0] time_bcd;

  always #5 sys_clk = ~sys_clk;

  ds1302_responder #(.CLK_FREQ(CLK_FREQ), .SYNC_STAGES(2)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .ds1302_ce     (ce),
    .ds1302_sclk   (sclk),
    .ds1302_io_in  (io),
    .ds1302_io_out (io_out),
    .ds1302_io_oe  (io_oe),
    .time_bcd      (time_bcd)
  );

  int checks = 0;
  int errors = 0;

  typedef enum {OP_WR, OP_RD, OP_IGN, OP_WAIT, OP_TIME} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  cmd;
    logic [7:0]  dat;
    logic [55:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];

  function automatic void add(op_e op, logic [7:0] cmd, logic [7:0] dat, logic [55:0] exp);
    vec_t v;
    v.op = op;  v.cmd = cmd;  v.dat = dat;  v.exp = exp;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(posedge sys_clk);
    #1;
  endtask

  // One CE-framed transaction; counts io_oe samples inside and outside the data phase.
  task automatic xfer(input logic [7:0] cmd, input logic [7:0] wd, input int nbits,
                      input bit rd_phase, output logic [7:0] rd,
                      output int oe_data, output int oe_other);
    rd = '0;  oe_data = 0;  oe_other = 0;
    ce = 1'b1;
    half();
    for (int i = 0; i < 8; i++) begin
      io = cmd[i];
      half();
      if (io_oe) oe_other++;
      sclk = 1'b1;
      half();
      if (io_oe) oe_other++;
      sclk = 1'b0;
    end
    if (rd_phase) begin
      io = 1'b0;
      for (int i = 0; i < 8; i++) begin
        half();
        rd[i] = io_out;
        if (io_oe) oe_data++;
        sclk = 1'b1;
        half();
        sclk = 1'b0;
      end
      half();
      if (io_oe) oe_other++;
    end else begin
      for (int i = 0; i < nbits; i++) begin
        io = wd[i];
        half();
        sclk = 1'b1;
        half();
        sclk = 1'b0;
      end
    end
    ce = 1'b0;
    io = 1'b0;
    half();
    if (io_oe) oe_other++;
    half();
  endtask

  task automatic do_rd(input logic [7:0] cmd, input logic [7:0] exp, input string nm);
    logic [7:0] rd;
    int oe_d, oe_o;
    exp_q.push_back(exp);
    xfer(cmd, 8'h00, 8, 1'b1, rd, oe_d, oe_o);
    chk({nm, "_data"}, rd, exp_q.pop_front());
    chk({nm, "_oe_bits"}, oe_d, 8);
    chk({nm, "_oe_outside"}, oe_o, 0);
  endtask

  task automatic do_wr(input logic [7:0] cmd, input logic [7:0] dat, input int nbits, input string nm);
    logic [7:0] rd;
    int oe_d, oe_o;
    xfer(cmd, dat, nbits, 1'b0, rd, oe_d, oe_o);
    chk({nm, "_oe"}, oe_d + oe_o, 0);
  endtask

  task automatic do_ign(input logic [7:0] cmd, input string nm);
    logic [7:0] rd;
    int oe_d, oe_o;
    xfer(cmd, 8'h00, 8, 1'b1, rd, oe_d, oe_o);
    chk({nm, "_oe"}, oe_d + oe_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset-state reads, then halt clock and load 31 Dec 99 23:59:59
    add(OP_RD, 8'h81, 8'h00, '0);
    add(OP_RD, 8'h87, 8'h00, 56'h01);
    add(OP_WR, 8'h80, 8'hD9, '0);
    add(OP_RD, 8'h85, 8'h00, 56'h00);
    add(OP_RD, 8'h8B, 8'h00, 56'h01);
    add(OP_RD, 8'h8F, 8'h00, 56'h00);
    add(OP_WR, 8'h82, 8'h59, '0);
    add(OP_WR, 8'h84, 8'h23, '0);
    add(OP_WR, 8'h86, 8'h31, '0);
    add(OP_WR, 8'h88, 8'h12, '0);
    add(OP_WR, 8'h8C, 8'h99, '0);
    add(OP_RD, 8'h81, 8'h00, 56'hD9);
    add(OP_RD, 8'h89, 8'h00, 56'h12);
    add(OP_RD, 8'h8D, 8'h00, 56'h99);
    add(OP_WR, 8'h80, 8'h59, '0);
    add(OP_WAIT, 8'h00, 8'h00, 56'd2300);
    add(OP_TIME, 8'h00, 8'h00, 56'h00_02_01_01_00_00_00);
    add(OP_RD, 8'h81, 8'h00, 56'h00);
    add(OP_RD, 8'h8B, 8'h00, 56'h02);
    // leap year 2024: 28 Feb -> 29 Feb
    add(OP_WR, 8'h80, 8'hD9, '0);
    add(OP_WR, 8'h8C, 8'h24, '0);
    add(OP_WR, 8'h88, 8'h02, '0);
    add(OP_WR, 8'h86, 8'h28, '0);
    add(OP_WR, 8'h84, 8'h23, '0);
    add(OP_WR, 8'h82, 8'h59, '0);
    add(OP_WR, 8'h80, 8'h59, '0);
    add(OP_WAIT, 8'h00, 8'h00, 56'd2300);
    add(OP_TIME, 8'h00, 8'h00, 56'h24_03_02_29_00_00_00);
    // 2023: 28 Feb -> 01 Mar
    add(OP_WR, 8'h80, 8'hD9, '0);
    add(OP_WR, 8'h8C, 8'h23, '0);
    add(OP_WR, 8'h88, 8'h02, '0);
    add(OP_WR, 8'h86, 8'h28, '0);
    add(OP_WR, 8'h84, 8'h23, '0);
    add(OP_WR, 8'h82, 8'h59, '0);
    add(OP_WR, 8'h80, 8'h59, '0);
    add(OP_WAIT, 8'h00, 8'h00, 56'd2300);
    add(OP_TIME, 8'h00, 8'h00, 56'h23_04_03_01_00_00_00);
    add(OP_RD, 8'h89, 8'h00, 56'h03);
    // write protect
    add(OP_WR, 8'h80, 8'h80, '0);
    add(OP_WR, 8'h8E, 8'h80, '0);
    add(OP_WR, 8'h80, 8'h30, '0);
    add(OP_WR, 8'h82, 8'h11, '0);
    add(OP_RD, 8'h81, 8'h00, 56'h80);
    add(OP_RD, 8'h83, 8'h00, 56'h00);
    add(OP_RD, 8'h8F, 8'h00, 56'h80);
    add(OP_WR, 8'h8E, 8'h00, '0);
    add(OP_RD, 8'h8F, 8'h00, 56'h00);
    add(OP_WR, 8'h80, 8'h30, '0);
    add(OP_RD, 8'h81, 8'h00, 56'h30);
    add(OP_TIME, 8'h00, 8'h00, 56'h23_04_03_01_00_00_30);
    // clock halt holds everything across three tick periods
    add(OP_WR, 8'h80, 8'h80, '0);
    add(OP_WAIT, 8'h00, 8'h00, 56'd6100);
    add(OP_TIME, 8'h00, 8'h00, 56'h23_04_03_01_00_00_00);
    add(OP_RD, 8'h81, 8'h00, 56'h80);
    // unsupported commands must not drive IO or touch registers
    add(OP_IGN, 8'hBF, 8'h00, '0);
    add(OP_IGN, 8'hC1, 8'h00, '0);
    add(OP_WR, 8'h40, 8'h12, '0);
    add(OP_WR, 8'h90, 8'h12, '0);
    add(OP_RD, 8'h81, 8'h00, 56'h80);
    add(OP_RD, 8'h83, 8'h00, 56'h00);

    repeat (5) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst_time", time_bcd, 56'h00_01_01_01_00_00_00);
    chk("rst_oe", io_oe, 1'b0);
    chk("rst_out", io_out, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d_%02h", i, tbl[i].cmd);
      case (tbl[i].op)
        OP_WR:   do_wr(tbl[i].cmd, tbl[i].dat, 8, nm);
        OP_RD:   do_rd(tbl[i].cmd, tbl[i].exp[7:0], nm);
        OP_IGN:  do_ign(tbl[i].cmd, nm);
        OP_WAIT: repeat (int'(tbl[i].exp)) @(posedge sys_clk);
        OP_TIME: begin
          #1;
          chk({nm, "_time"}, time_bcd, tbl[i].exp);
        end
        default: ;
      endcase
    end

    // CE dropped after 5 data bits: no commit, responder back to idle
    do_wr(8'h82, 8'h45, 5, "abort_wr");
    chk("abort_time", time_bcd, 56'h23_04_03_01_00_00_00);
    do_rd(8'h83, 8'h00, "after_abort");
    do_wr(8'h82, 8'h45, 8, "full_wr");
    chk("full_wr_time", time_bcd, 56'h23_04_03_01_00_45_00);
    do_rd(8'h83, 8'h45, "full_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
